// File: rtl/audio_multichan_bridge.sv
// audio_multichan_bridge: per-channel sample FIFOs drained by the CPU over a
// small register bus, with status, control (irq enable + flush) and a
// threshold interrupt. Optional macro AUDIO_BRIDGE_OVF_CNT_EN adds a
// saturating clear-on-read dropped-sample counter at address 10.
module audio_multichan_bridge #(
  parameter int unsigned DATA_SIZE  = 28,
  parameter int unsigned DEPTH      = 2048,
  parameter int unsigned CHANNELS   = 2,
  parameter int unsigned IRQ_THRESH = DEPTH / 2,
  parameter int unsigned ADDR_WIDTH = $clog2(DEPTH)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 chipselect,
  input  logic [3:0]           address,
  input  logic                 read,
  input  logic                 write,
  input  logic [31:0]          write_data,
  output logic [31:0]          read_data,
  input  logic                 source_valid,
  input  logic [2:0]           source_channel,
  input  logic [DATA_SIZE-1:0] source_data,
  output logic [CHANNELS-1:0]  source_ready,
  output logic                 irq
);

  localparam int unsigned CW = ADDR_WIDTH + 1;
  localparam logic [CW-1:0]         FULL_CNT   = CW'(DEPTH);
  localparam logic [CW-1:0]         THRESH_CNT = CW'(IRQ_THRESH);
  localparam logic [ADDR_WIDTH-1:0] PTR_ONE    = ADDR_WIDTH'(1);

  logic [ADDR_WIDTH-1:0] wr_ptr_q [CHANNELS];
  logic [ADDR_WIDTH-1:0] wr_ptr_d [CHANNELS];
  logic [ADDR_WIDTH-1:0] rd_ptr_q [CHANNELS];
  logic [ADDR_WIDTH-1:0] rd_ptr_d [CHANNELS];
  logic [CW-1:0]         cnt_q    [CHANNELS];
  logic [CW-1:0]         cnt_d    [CHANNELS];
  logic [DATA_SIZE-1:0]  mem_q    [CHANNELS][DEPTH];

  logic [7:0]  irq_en_q, irq_en_d;
  logic [7:0]  ovf_q, ovf_d;
  logic [31:0] read_data_q, read_data_d;
  logic        irq_q, irq_d;

  logic [CHANNELS-1:0]  full_c, empty_c, push_c, pop_c, drop_c;
  logic [7:0]           ne_c, th_c;
  logic [DATA_SIZE-1:0] pop_word_c;
  logic                 bus_rd_c, bus_wr_c, flush_c;
  logic                 unused_wd;

`ifdef AUDIO_BRIDGE_OVF_CNT_EN
  logic [15:0] ovf_cnt_q, ovf_cnt_d;
`endif

  assign bus_rd_c  = chipselect & read;
  assign bus_wr_c  = chipselect & write;
  assign flush_c   = bus_wr_c && (address == 4'd9) && write_data[31];
  assign unused_wd = ^write_data[30:8];

  // Per-channel occupancy flags derived from the counts.
  always_comb begin
    full_c  = '0;
    empty_c = '0;
    ne_c    = '0;
    th_c    = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      full_c[c]  = (cnt_q[c] == FULL_CNT);
      empty_c[c] = (cnt_q[c] == '0);
      ne_c[c]    = (cnt_q[c] != '0);
      th_c[c]    = (cnt_q[c] >= THRESH_CNT);
    end
  end

  // Decode which channel pushes, drops or pops this cycle.
  always_comb begin
    push_c     = '0;
    drop_c     = '0;
    pop_c      = '0;
    pop_word_c = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      if (source_valid && (source_channel == 3'(c))) begin
        push_c[c] = !full_c[c];
        drop_c[c] = full_c[c];
      end
      if (bus_rd_c && !address[3] && (address[2:0] == 3'(c))) begin
        pop_c[c]   = !empty_c[c];
        pop_word_c = mem_q[c][rd_ptr_q[c]];
      end
    end
  end

  // Next-state for pointers, counts, bus read data and control/status.
  always_comb begin
    for (int c = 0; c < CHANNELS; c++) begin
      wr_ptr_d[c] = wr_ptr_q[c];
      rd_ptr_d[c] = rd_ptr_q[c];
      cnt_d[c]    = cnt_q[c];
    end
    irq_en_d    = irq_en_q;
    ovf_d       = ovf_q;
    read_data_d = read_data_q;
    irq_d       = |(irq_en_q[CHANNELS-1:0] & th_c[CHANNELS-1:0]);

    for (int c = 0; c < CHANNELS; c++) begin
      if (push_c[c]) wr_ptr_d[c] = wr_ptr_q[c] + PTR_ONE;
      if (pop_c[c])  rd_ptr_d[c] = rd_ptr_q[c] + PTR_ONE;
      cnt_d[c] = cnt_q[c] + CW'(push_c[c]) - CW'(pop_c[c]);
    end

    // Flush overrides any push/pop in the same cycle.
    if (flush_c) begin
      for (int c = 0; c < CHANNELS; c++) begin
        wr_ptr_d[c] = '0;
        rd_ptr_d[c] = '0;
        cnt_d[c]    = '0;
      end
    end

    if (bus_rd_c) begin
      if (!address[3]) begin
        read_data_d = (|pop_c) ? (32'(pop_word_c) | 32'h8000_0000) : 32'h0;
      end else begin
        case (address)
          4'd8: begin
            read_data_d = {8'h00, ovf_q, th_c, ne_c};
            ovf_d       = '0;
          end
          4'd9:  read_data_d = {24'h0, irq_en_q};
`ifdef AUDIO_BRIDGE_OVF_CNT_EN
          4'd10: read_data_d = {16'h0, ovf_cnt_q};
`endif
          default: read_data_d = 32'h0;
        endcase
      end
    end

    if (bus_wr_c && (address == 4'd9)) irq_en_d = write_data[7:0];

    // A new drop wins over a same-cycle status clear.
    for (int c = 0; c < CHANNELS; c++) begin
      if (drop_c[c]) ovf_d[c] = 1'b1;
    end
  end

  // Pointer, count, control and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int c = 0; c < CHANNELS; c++) begin
        wr_ptr_q[c] <= '0;
        rd_ptr_q[c] <= '0;
        cnt_q[c]    <= '0;
      end
      irq_en_q    <= '0;
      ovf_q       <= '0;
      read_data_q <= '0;
      irq_q       <= 1'b0;
    end else begin
      for (int c = 0; c < CHANNELS; c++) begin
        wr_ptr_q[c] <= wr_ptr_d[c];
        rd_ptr_q[c] <= rd_ptr_d[c];
        cnt_q[c]    <= cnt_d[c];
      end
      irq_en_q    <= irq_en_d;
      ovf_q       <= ovf_d;
      read_data_q <= read_data_d;
      irq_q       <= irq_d;
    end
  end

  // Sample storage; not reset, a flushed push is discarded.
  always_ff @(posedge clk) begin
    for (int c = 0; c < CHANNELS; c++) begin
      if (push_c[c] && !flush_c) mem_q[c][wr_ptr_q[c]] <= source_data;
    end
  end

`ifdef AUDIO_BRIDGE_OVF_CNT_EN
  // Saturating dropped-sample counter, cleared by reading it.
  always_comb begin
    ovf_cnt_d = ovf_cnt_q;
    if (bus_rd_c && (address == 4'd10)) ovf_cnt_d = '0;
    if ((|drop_c) && (ovf_cnt_d != 16'hFFFF)) ovf_cnt_d = ovf_cnt_d + 16'd1;
  end

  // Dropped-sample counter register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) ovf_cnt_q <= '0;
    else     ovf_cnt_q <= ovf_cnt_d;
  end
`endif

  assign read_data    = read_data_q;
  assign irq          = irq_q;
  assign source_ready = ~full_c;

endmodule
